reorder_buffer: RTL and testbench

- Circular in-order commit queue between issue and the architectural register file.
- Allocates a 4-bit tag per issued instruction and captures results from the common data bus (CDB).
- Retires entries from the head and drives the register file's commit write port (value plus tag-match release).
- On a branch mispredict, raises the global RoB_clear flush with a redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/reorder_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: entry type encodings, tag width,
// default depth and the per-entry payload record.
package reorder_buffer_pkg;

    localparam int TAG_W     = 4;
    localparam int ROB_DEPTH = 16;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2,
        ROB_NOP    = 2'd3
    } rob_type_e;

    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates tags at issue, captures CDB results,
// retires from the head and flushes everything on a branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        issue_valid,
    input  logic [1:0]  issue_type,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_pc,
    input  logic        issue_pred,
    output logic [3:0]  alloc_tag,
    output logic        full,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [31:0] cdb_val,
    input  logic        cdb_taken,
    input  logic [31:0] cdb_target,
    input  logic [3:0]  query_tag_1,
    input  logic [3:0]  query_tag_2,
    output logic        query_ready_1,
    output logic        query_ready_2,
    output logic [31:0] query_val_1,
    output logic [31:0] query_val_2,
    output logic [4:0]  commit_reg,
    output logic [31:0] commit_val,
    output logic [4:0]  commit_q_reg,
    output logic [31:0] commit_q_tag,
    output logic        store_commit,
    output logic [3:0]  store_tag,
    output logic        RoB_clear,
    output logic [31:0] clear_pc
);

    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    rob_entry_t       entry_q [DEPTH];
    rob_entry_t       entry_d [DEPTH];

    logic [4:0]  commit_reg_q, commit_reg_d, commit_q_reg_q, commit_q_reg_d;
    logic [31:0] commit_val_q, commit_val_d, commit_q_tag_q, commit_q_tag_d;
    logic        store_commit_q, store_commit_d, rob_clear_q, rob_clear_d;
    logic [3:0]  store_tag_q, store_tag_d;
    logic [31:0] clear_pc_q, clear_pc_d;

    logic       alloc_go, commit_go, mispredict;
    rob_entry_t head_e, new_e;
    logic       q1_bypass, q1_stored, q2_bypass, q2_stored;

    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign alloc_tag = tail_q;

    // The cycle after a flush is also blind to issue and CDB traffic.
    assign alloc_go   = issue_valid && !full && !rob_clear_q;
    assign head_e     = entry_q[head_q];
    assign commit_go  = (count_q != '0) && ready_q[head_q];
    assign mispredict = commit_go && (head_e.typ == ROB_BRANCH) && (head_e.taken != head_e.pred);

    always_comb begin
        new_e        = '0;
        new_e.typ    = rob_type_e'(issue_type);
        new_e.rd     = issue_rd;
        new_e.pc     = issue_pc;
        new_e.pred   = issue_pred;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        entry_d        = entry_q;
        commit_reg_d   = '0;
        commit_val_d   = '0;
        commit_q_reg_d = '0;
        commit_q_tag_d = '0;
        store_commit_d = 1'b0;
        store_tag_d    = '0;
        rob_clear_d    = 1'b0;
        clear_pc_d     = '0;

        if (rdy_in) begin
            if (commit_go) begin
                unique case (head_e.typ)
                    ROB_REG: begin
                        commit_reg_d   = head_e.rd;
                        commit_val_d   = head_e.val;
                        commit_q_reg_d = head_e.rd;
                        commit_q_tag_d = {{(32-TAG_W){1'b0}}, head_q};
                    end
                    ROB_STORE: begin
                        store_commit_d = 1'b1;
                        store_tag_d    = head_q;
                    end
                    ROB_BRANCH: begin
                        if (mispredict) begin
                            rob_clear_d = 1'b1;
                            clear_pc_d  = head_e.taken ? head_e.target : head_e.pc + 32'd4;
                        end
                    end
                    default: ;
                endcase
            end

            if (mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                ready_d = '0;
            end else begin
                if (cdb_valid && !rob_clear_q && busy_q[cdb_tag]) begin
                    ready_d[cdb_tag]        = 1'b1;
                    entry_d[cdb_tag].val    = cdb_val;
                    entry_d[cdb_tag].taken  = cdb_taken;
                    entry_d[cdb_tag].target = cdb_target;
                end
                if (commit_go) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = ptr_inc(head_q);
                end
                if (alloc_go) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = (issue_type == ROB_NOP);
                    entry_d[tail_q] = new_e;
                    tail_d          = ptr_inc(tail_q);
                end
                count_d = count_q + CNT_W'(alloc_go) - CNT_W'(commit_go);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_reg_q   <= '0;
            commit_val_q   <= '0;
            commit_q_reg_q <= '0;
            commit_q_tag_q <= '0;
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
            rob_clear_q    <= 1'b0;
            clear_pc_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_reg_q   <= commit_reg_d;
            commit_val_q   <= commit_val_d;
            commit_q_reg_q <= commit_q_reg_d;
            commit_q_tag_q <= commit_q_tag_d;
            store_commit_q <= store_commit_d;
            store_tag_q    <= store_tag_d;
            rob_clear_q    <= rob_clear_d;
            clear_pc_q     <= clear_pc_d;
        end
    end

    // NOTE: payload storage has no reset; busy/ready gate every read of it.
    always_ff @(posedge clk_in) begin
        entry_q <= entry_d;
    end

    assign commit_reg   = commit_reg_q;
    assign commit_val   = commit_val_q;
    assign commit_q_reg = commit_q_reg_q;
    assign commit_q_tag = commit_q_tag_q;
    assign store_commit = store_commit_q;
    assign store_tag    = store_tag_q;
    assign RoB_clear    = rob_clear_q;
    assign clear_pc     = clear_pc_q;

    // A same-cycle CDB broadcast wins over stored state for operand lookup.
    assign q1_bypass     = cdb_valid && (cdb_tag == query_tag_1);
    assign q1_stored     = busy_q[query_tag_1] && ready_q[query_tag_1];
    assign query_ready_1 = q1_bypass || q1_stored;
    assign query_val_1   = q1_bypass ? cdb_val : (q1_stored ? entry_q[query_tag_1].val : '0);

    assign q2_bypass     = cdb_valid && (cdb_tag == query_tag_2);
    assign q2_stored     = busy_q[query_tag_2] && ready_q[query_tag_2];
    assign query_ready_2 = q2_bypass || q2_stored;
    assign query_val_2   = q2_bypass ? cdb_val : (q2_stored ? entry_q[query_tag_2].val : '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based
// model of the in-order commit rules.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk, rst_in, rdy_in;
    logic        issue_valid, issue_pred;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [3:0]  alloc_tag;
    logic        full;
    logic        cdb_valid, cdb_taken;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_target;
    logic [3:0]  query_tag_1, query_tag_2;
    logic        query_ready_1, query_ready_2;
    logic [31:0] query_val_1, query_val_2;
    logic [4:0]  commit_reg, commit_q_reg;
    logic [31:0] commit_val, commit_q_tag;
    logic        store_commit;
    logic [3:0]  store_tag;
    logic        RoB_clear;
    logic [31:0] clear_pc;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred(issue_pred),
        .alloc_tag(alloc_tag), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
        .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
        .query_val_1(query_val_1), .query_val_2(query_val_2),
        .commit_reg(commit_reg), .commit_val(commit_val),
        .commit_q_reg(commit_q_reg), .commit_q_tag(commit_q_tag),
        .store_commit(store_commit), .store_tag(store_tag),
        .RoB_clear(RoB_clear), .clear_pc(clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: in-flight instructions in program order, oldest first.
    typedef struct {
        int          tag;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        rdy;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_head;
    logic [4:0]  e_reg, e_qreg;
    logic [31:0] e_val, e_qtag, e_clear_pc;
    logic        e_store, e_clear;
    logic [3:0]  e_store_tag;

    function automatic int m_find(input int tag);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_head = 0;
        e_reg = '0; e_qreg = '0; e_val = '0; e_qtag = '0;
        e_store = 1'b0; e_store_tag = '0; e_clear = 1'b0; e_clear_pc = '0;
    endtask

    task automatic exp_query(input logic [3:0] t, output logic r, output logic [31:0] v);
        int idx;
        r = 1'b0; v = '0;
        idx = m_find(int'(t));
        if (cdb_valid && cdb_tag == t) begin
            r = 1'b1; v = cdb_val;
        end else if (idx >= 0 && mq[idx].rdy) begin
            r = 1'b1; v = mq[idx].val;
        end
    endtask

    task automatic m_edge();
        logic   was_full, was_clear;
        m_ent_t h, n;
        int     idx;
        was_full  = (mq.size() == 16);
        was_clear = e_clear;
        e_reg = '0; e_qreg = '0; e_val = '0; e_qtag = '0;
        e_store = 1'b0; e_store_tag = '0; e_clear = 1'b0; e_clear_pc = '0;
        if (!rdy_in) return;
        if (mq.size() > 0 && mq[0].rdy) begin
            h = mq[0];
            if (h.typ == ROB_REG) begin
                e_reg = h.rd; e_qreg = h.rd; e_val = h.val; e_qtag = 32'(m_head);
            end else if (h.typ == ROB_STORE) begin
                e_store = 1'b1; e_store_tag = 4'(m_head);
            end else if (h.typ == ROB_BRANCH && h.taken != h.pred) begin
                e_clear    = 1'b1;
                e_clear_pc = h.taken ? h.target : h.pc + 32'd4;
                mq.delete();
                m_head = 0;
                return;
            end
            mq.delete(0);
            m_head = (m_head + 1) % 16;
        end
        if (cdb_valid && !was_clear) begin
            idx = m_find(int'(cdb_tag));
            if (idx >= 0) begin
                mq[idx].rdy = 1'b1; mq[idx].val = cdb_val;
                mq[idx].taken = cdb_taken; mq[idx].target = cdb_target;
            end
        end
        if (issue_valid && !was_full && !was_clear) begin
            n = '{tag: (m_head + mq.size()) % 16, typ: issue_type, rd: issue_rd, pc: issue_pc,
                  pred: issue_pred, rdy: (issue_type == ROB_NOP), val: '0, taken: 1'b0, target: '0};
            mq.push_back(n);
        end
    endtask

    // One clock: combinational checks at the falling edge, registered checks 1ns after the rising edge.
    task automatic step();
        logic        r;
        logic [31:0] v;
        @(negedge clk);
        check("alloc_tag", alloc_tag, 32'((m_head + mq.size()) % 16));
        check("full", full, mq.size() == 16);
        exp_query(query_tag_1, r, v);
        check("q1_ready", query_ready_1, r);
        check("q1_val", query_val_1, v);
        exp_query(query_tag_2, r, v);
        check("q2_ready", query_ready_2, r);
        check("q2_val", query_val_2, v);
        @(posedge clk);
        m_edge();
        #1;
        check("commit_reg", commit_reg, e_reg);
        check("commit_val", commit_val, e_val);
        check("commit_q_reg", commit_q_reg, e_qreg);
        check("commit_q_tag", commit_q_tag, e_qtag);
        check("store_commit", store_commit, e_store);
        check("store_tag", store_tag, e_store_tag);
        check("rob_clear", RoB_clear, e_clear);
        check("clear_pc", clear_pc, e_clear_pc);
    endtask

    task automatic set_idle();
        rdy_in = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
        issue_type = ROB_REG; issue_rd = '0; issue_pc = '0; issue_pred = 1'b0;
        cdb_tag = '0; cdb_val = '0; cdb_taken = 1'b0; cdb_target = '0;
        query_tag_1 = '0; query_tag_2 = '0;
    endtask

    task automatic reset_dut();
        set_idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        m_reset();
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred = pred;
    endtask

    task automatic set_cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_tag = t; cdb_val = v; cdb_taken = tk; cdb_target = tgt;
    endtask

    task automatic run_branch(input string nm, input logic pred, input logic tk, input logic [31:0] tgt,
                              input logic exp_clear, input logic [31:0] exp_pc);
        logic        got_clear, got_r3;
        logic [31:0] got_pc;
        reset_dut();
        set_issue(ROB_BRANCH, 5'd0, 32'h100, pred); step();
        set_issue(ROB_REG, 5'd3, 32'h104, 1'b0);    step();
        issue_valid = 1'b0;
        set_cdb(4'd1, 32'h33, 1'b0, '0);            step();
        set_cdb(4'd0, '0, tk, tgt);                 step();
        cdb_valid = 1'b0;
        got_clear = 1'b0; got_r3 = 1'b0; got_pc = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (RoB_clear) begin got_clear = 1'b1; got_pc = clear_pc; end
            if (commit_reg == 5'd3) got_r3 = 1'b1;
        end
        check({nm, "_clear_seen"}, got_clear, exp_clear);
        check({nm, "_clear_pc"}, got_pc, exp_pc);
        check({nm, "_rd3_commit"}, got_r3, !exp_clear);
        check({nm, "_alloc_after"}, alloc_tag, exp_clear ? 32'd0 : 32'd2);
    endtask

    initial begin
        int idx;
        set_idle();
        m_reset();
        reset_dut();
        check("reset_alloc_tag", alloc_tag, 0);
        check("reset_full", full, 0);
        check("reset_rob_clear", RoB_clear, 0);

        // Basic REG commit.
        set_issue(ROB_REG, 5'd5, 32'h0, 1'b0); step();
        issue_valid = 1'b0;
        set_cdb(4'd0, 32'h1234, 1'b0, '0); step();
        cdb_valid = 1'b0; step();
        check("t1_commit_reg", commit_reg, 5);
        check("t1_commit_val", commit_val, 32'h1234);
        check("t1_commit_q_tag", commit_q_tag, 0);

        // Fill, overflow attempt, drain one, wrap.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            set_issue(ROB_REG, 5'(i + 1), 32'(i * 4), 1'b0); step();
        end
        check("t2_full", full, 1);
        step();
        issue_valid = 1'b0;
        check("t2_overflow_alloc_tag", alloc_tag, 0);
        check("t2_overflow_full", full, 1);
        set_cdb(4'd0, 32'hA0, 1'b0, '0); step();
        cdb_valid = 1'b0; step();
        check("t2_drain_commit_reg", commit_reg, 1);
        check("t2_not_full", full, 0);
        check("t2_wrap_tag", alloc_tag, 0);
        set_issue(ROB_STORE, 5'd0, 32'h40, 1'b0); step();
        issue_valid = 1'b0;
        check("t2_tail_after_wrap", alloc_tag, 1);

        run_branch("t3", 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
        run_branch("t4", 1'b1, 1'b0, 32'h200, 1'b1, 32'h104);
        run_branch("t4b", 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);

        // Query bypass then stored value.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            set_issue(ROB_REG, 5'(i + 1), 32'(i * 4), 1'b0); step();
        end
        issue_valid = 1'b0;
        query_tag_1 = 4'd2; query_tag_2 = 4'd1;
        set_cdb(4'd2, 32'hBEEF, 1'b0, '0);
        #2;
        check("t5_bypass_ready", query_ready_1, 1);
        check("t5_bypass_val", query_val_1, 32'hBEEF);
        check("t5_other_not_ready", query_ready_2, 0);
        step();
        cdb_valid = 1'b0;
        #2;
        check("t5_stored_ready", query_ready_1, 1);
        check("t5_stored_val", query_val_1, 32'hBEEF);
        step();

        // Async reset with 7 pending entries and a commit pulse on the outputs.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            set_issue(ROB_REG, 5'(i + 1), 32'(i * 4), 1'b0); step();
        end
        issue_valid = 1'b0;
        set_cdb(4'd0, 32'h77, 1'b0, '0); step();
        cdb_valid = 1'b0; step();
        check("t6_pre_commit_reg", commit_reg, 1);
        check("t6_pre_alloc_tag", alloc_tag, 8);
        #2;
        rst_in = 1'b1;
        #1;
        check("t6_async_commit_reg", commit_reg, 0);
        check("t6_async_commit_val", commit_val, 0);
        check("t6_async_alloc_tag", alloc_tag, 0);
        reset_dut();
        check("t6_alloc_tag_after", alloc_tag, 0);
        check("t6_full_after", full, 0);

        // Randomized traffic.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rdy_in = ($urandom_range(9) != 0);
            issue_valid = 1'b0;
            if (mq.size() < 16 && $urandom_range(1) == 1)
                set_issue(2'($urandom_range(3)), 5'($urandom_range(31)), $urandom & 32'hFFFF_FFFC,
                          1'($urandom_range(1)));
            cdb_valid = 1'b0;
            if ($urandom_range(9) < 5) begin
                idx = (mq.size() > 0) ? int'($urandom_range(mq.size() - 1)) : -1;
                set_cdb((idx >= 0 && $urandom_range(4) != 0) ? 4'(mq[idx].tag) : 4'($urandom_range(15)),
                        $urandom, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC);
            end
            query_tag_1 = 4'($urandom_range(15));
            query_tag_2 = (cdb_valid && $urandom_range(1) == 1) ? cdb_tag : 4'($urandom_range(15));
            step();
        end
        set_idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
